// File: rtl/multicycle_controller.sv
// multicycle_controller
// ---------------------
// Main sequencing FSM for the multicycle rv32i core. The core has one shared
// instruction/data memory, IR/OldPC/ALUOut/Data registers and a single ALU.
// That ALU is reused for PC+4, for the branch/JAL target and for execution.
// Each cycle the controller turns the current state and the latched opcode
// fields into datapath selects and write enables. The ALU-function decoder is
// a separate block, driven by alu_op_o.
//
// Ports
//   clk_i, rst_i       : clock (rising edge); synchronous active-high reset
//   op_i, funct3_i     : IR[6:0] and IR[14:12]; stable after FETCH
//   zero_i             : ALU zero flag
//   less_than_i        : ALU result bit 0 (slt/sltu outcome)
//   mem_ready_i        : memory completes the current request this cycle
//   mem_req_o          : memory request valid
//   mem_write_o        : request is a store
//   adr_src_o          : memory address select (0 PC, 1 ALUOut)
//   ir_write_o         : load IR and OldPC
//   pc_write_o         : load PC from the result bus
//   reg_write_o        : register-file write
//   alu_src_a_o        : ALU A select (00 PC, 01 OldPC, 10 rs1, 11 zero)
//   alu_src_b_o        : ALU B select (00 rs2, 01 imm_ext, 10 constant 4)
//   alu_op_o           : ALU op class (00 add, 01 branch compare, 10 funct)
//   result_src_o       : result bus select (00 ALUOut, 01 Data, 10 ALU direct)
//   trap_o             : illegal opcode seen; core halted
//   state_o            : registered state encoding, for debug
module multicycle_controller (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       less_than_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic       trap_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_UPPER     = 4'd12,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_reg;
  state_t state_next;
  logic   branch_taken;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Branch outcome. The ALU has already computed either rs1-rs2 (zero flag)
  // or the signed/unsigned less-than, as chosen by the ALU decoder from funct3.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3_i)
      3'b000:          branch_taken = zero_i;
      3'b001:          branch_taken = ~zero_i;
      3'b100, 3'b110:  branch_taken = less_than_i;
      3'b101, 3'b111:  branch_taken = ~less_than_i;
      default:         branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    result_src_o = 2'b00;
    trap_o       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        // The ALU forms PC+4 and drives it straight onto the result bus, so
        // the PC and IR update together on the cycle the memory completes.
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
        if (mem_ready_i) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute OldPC+imm into ALUOut for branch and JAL.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI, OP_AUIPC:  state_next = S_UPPER;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        // op_i[5] separates store (0100011) from load (0000011).
        state_next  = op_i[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) begin
          state_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        if (mem_ready_i) begin
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
        state_next  = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
        state_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        // The ALU is busy comparing; the target comes from ALUOut.
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_write_o  = branch_taken;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link
        // value OldPC+4, which ALU_WB then writes back from ALUOut.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_next  = S_ALU_WB;
      end
      S_JALR: begin
        // Overwrite ALUOut with rs1+imm, then reuse the JAL sequence.
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_next  = S_JAL;
      end
      S_UPPER: begin
        // lui adds the immediate to zero; auipc adds it to OldPC.
        alu_src_a_o = op_i[5] ? 2'b11 : 2'b01;
        alu_src_b_o = 2'b01;
        state_next  = S_ALU_WB;
      end
      S_TRAP: begin
        trap_o     = 1'b1;
        state_next = S_TRAP;
      end
      default: begin
        // Unused encodings can only be reached by an upset; halt safely.
        state_next = S_TRAP;
      end
    endcase

    // Reset wins over everything: no enables, all selects parked at zero, and
    // any in-flight memory request is abandoned.
    if (rst_i) begin
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      adr_src_o    = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      result_src_o = 2'b00;
      trap_o       = 1'b0;
    end
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Each task walks one instruction
// (or scenario) cycle by cycle, with hand-written expected state sequences and
// outputs, and checks them inline.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       less_than;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       trap;
  logic [3:0] state;

  logic [5:0] en;
  logic [7:0] sel;
  assign en  = {mem_req, mem_write, ir_write, pc_write, reg_write, trap};
  assign sel = {alu_src_a, alu_src_b, alu_op, result_src};

  int vectors;
  int miscompares;

  multicycle_controller dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .op_i         (op),
    .funct3_i     (funct3),
    .zero_i       (zero),
    .less_than_i  (less_than),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .adr_src_o    (adr_src),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .result_src_o (result_src),
    .trap_o       (trap),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; op = 7'b0; funct3 = 3'b0;
    zero = 1'b0; less_than = 1'b0;
    tick(); tick();
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    vectors++;
    if (en !== 6'b0) begin
      miscompares++; $display("FAIL reset_enables got=%b exp=000000", en);
    end
    vectors++;
    if ({adr_src, sel} !== 9'b0) begin
      miscompares++; $display("FAIL reset_selects got=%b exp=000000000", {adr_src, sel});
    end
    rst = 1'b0;
    #2;
    vectors++;
    if ({mem_req, ir_write, pc_write} !== 3'b111) begin
      miscompares++; $display("FAIL reset_release_fetch got=%b exp=111", {mem_req, ir_write, pc_write});
    end
    // Stall FETCH for one cycle: no IR/PC write, request held.
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({mem_req, ir_write, pc_write, sel} !== {3'b100, 8'b00_10_00_10}) begin
      miscompares++; $display("FAIL fetch_stall_outputs got=%b exp=10000100010", {mem_req, ir_write, pc_write, sel});
    end
    tick();
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL fetch_stall_state got=%0d exp=0", state);
    end
    $display("reset: release and fetch stall checked");
  endtask

  task automatic test_addi();
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd7, 4'd8};
    op = 7'b0010011; funct3 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #2;
      vectors++;
      if (state !== st[i]) begin
        miscompares++; $display("FAIL addi_state cyc=%0d got=%0d exp=%0d", i, state, st[i]);
      end
      vectors++;
      if (reg_write !== (st[i] == 4'd8)) begin
        miscompares++; $display("FAIL addi_reg_write cyc=%0d got=%b", i, reg_write);
      end
      if (st[i] == 4'd7) begin
        vectors++;
        if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_01_10) begin
          miscompares++; $display("FAIL addi_exec_sel got=%b exp=100110", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (st[i] == 4'd8) begin
        vectors++;
        if (result_src !== 2'b00) begin
          miscompares++; $display("FAIL addi_result_src got=%b exp=00", result_src);
        end
      end
      tick();
    end
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL addi_end_state got=%0d exp=0", state);
    end
    $display("addi: 4-cycle sequence checked");
  endtask

  task automatic test_lw();
    logic [3:0] st  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #2;
      vectors++;
      if (state !== st[i]) begin
        miscompares++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state, st[i]);
      end
      if (st[i] == 4'd3) begin
        vectors++;
        if ({mem_req, adr_src, mem_write, reg_write} !== 4'b1100) begin
          miscompares++; $display("FAIL lw_mem_read cyc=%0d got=%b exp=1100", i, {mem_req, adr_src, mem_write, reg_write});
        end
      end
      if (st[i] == 4'd4) begin
        vectors++;
        if ({reg_write, result_src, mem_req} !== 4'b1010) begin
          miscompares++; $display("FAIL lw_mem_wb got=%b exp=1010", {reg_write, result_src, mem_req});
        end
      end
      tick();
    end
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL lw_end_state got=%0d exp=0", state);
    end
    $display("lw: 2-cycle MEM_READ stall checked");
  endtask

  task automatic test_sw();
    logic [3:0] st  [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic       rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #2;
      vectors++;
      if (state !== st[i]) begin
        miscompares++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, state, st[i]);
      end
      if (st[i] == 4'd5) begin
        vectors++;
        if ({mem_req, mem_write, adr_src, reg_write} !== 4'b1110) begin
          miscompares++; $display("FAIL sw_mem_write cyc=%0d got=%b exp=1110", i, {mem_req, mem_write, adr_src, reg_write});
        end
      end
      tick();
    end
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL sw_end_state got=%0d exp=0", state);
    end
    $display("sw: 1-cycle MEM_WRITE stall checked");
  endtask

  task automatic test_branch();
    // funct3, zero, less_than, expected taken
    logic [2:0] f3 [6] = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b101, 3'b010};
    logic       zf [6] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
    logic       lt [6] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
    logic       tk [6] = '{1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0};
    op = 7'b1100011; mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      funct3 = f3[k]; zero = zf[k]; less_than = lt[k];
      tick();
      #2;
      vectors++;
      if (state !== 4'd1) begin
        miscompares++; $display("FAIL br_decode_state k=%0d got=%0d exp=1", k, state);
      end
      tick();
      #2;
      vectors++;
      if (state !== 4'd9) begin
        miscompares++; $display("FAIL br_state k=%0d got=%0d exp=9", k, state);
      end
      vectors++;
      if (pc_write !== tk[k]) begin
        miscompares++; $display("FAIL br_taken k=%0d f3=%b got=%b exp=%b", k, f3[k], pc_write, tk[k]);
      end
      vectors++;
      if ({alu_src_a, alu_src_b, alu_op, result_src} !== 8'b10_00_01_00) begin
        miscompares++; $display("FAIL br_sel k=%0d got=%b exp=10000100", k, sel);
      end
      tick();
      #2;
      vectors++;
      if (state !== 4'd0) begin
        miscompares++; $display("FAIL br_end_state k=%0d got=%0d exp=0", k, state);
      end
      $display("branch: funct3=%b zero=%b lt=%b taken=%b", f3[k], zf[k], lt[k], pc_write);
    end
    zero = 1'b0; less_than = 1'b0;
  endtask

  task automatic test_jalr();
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd8};
    logic       pw [5] = '{1'b1, 1'b0, 1'b0,  1'b1,  1'b0};
    op = 7'b1100111; funct3 = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      vectors++;
      if (state !== st[i]) begin
        miscompares++; $display("FAIL jalr_state cyc=%0d got=%0d exp=%0d", i, state, st[i]);
      end
      vectors++;
      if ({pc_write, reg_write} !== {pw[i], st[i] == 4'd8}) begin
        miscompares++; $display("FAIL jalr_writes cyc=%0d got=%b", i, {pc_write, reg_write});
      end
      if (st[i] == 4'd10) begin
        vectors++;
        if ({alu_src_a, alu_src_b, alu_op, result_src} !== 8'b01_10_00_00) begin
          miscompares++; $display("FAIL jal_sel got=%b exp=01100000", sel);
        end
      end
      tick();
    end
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL jalr_end_state got=%0d exp=0", state);
    end
    $display("jalr: 5-cycle sequence checked");
  endtask

  task automatic test_upper();
    logic [6:0] ops [2] = '{7'b0110111, 7'b0010111};
    logic [1:0] exp_a [2] = '{2'b11, 2'b01};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      tick(); tick();
      #2;
      vectors++;
      if ({state, alu_src_a, alu_src_b} !== {4'd12, exp_a[k], 2'b01}) begin
        miscompares++; $display("FAIL upper k=%0d got=%0d/%b/%b exp=12/%b/01", k, state, alu_src_a, alu_src_b, exp_a[k]);
      end
      tick();
      #2;
      vectors++;
      if ({state, reg_write} !== {4'd8, 1'b1}) begin
        miscompares++; $display("FAIL upper_wb k=%0d got=%0d/%b exp=8/1", k, state, reg_write);
      end
      tick();
      $display("upper: op=%b checked", ops[k]);
    end
  endtask

  task automatic test_trap();
    op = 7'b0001111; mem_ready = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      #2;
      vectors++;
      if ({state, en} !== {4'd15, 6'b000001}) begin
        miscompares++; $display("FAIL trap cyc=%0d got=%0d/%b exp=15/000001", i, state, en);
      end
      tick();
    end
    rst = 1'b1;
    #2;
    vectors++;
    if (en !== 6'b0) begin
      miscompares++; $display("FAIL trap_reset_enables got=%b exp=000000", en);
    end
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL trap_reset_state got=%0d exp=0", state);
    end
    $display("trap: held 10 cycles and cleared by reset");
  endtask

  task automatic test_reset_mid_request();
    op = 7'b0000011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #2;
    vectors++;
    if (state !== 4'd3) begin
      miscompares++; $display("FAIL midreq_state got=%0d exp=3", state);
    end
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    vectors++;
    if ({en, adr_src, sel} !== 15'b0) begin
      miscompares++; $display("FAIL midreq_forced got=%b exp=0", {en, adr_src, sel});
    end
    tick();
    rst = 1'b0; mem_ready = 1'b0;
    #2;
    vectors++;
    if (state !== 4'd0) begin
      miscompares++; $display("FAIL midreq_after got=%0d exp=0", state);
    end
    $display("reset mid-request: MEM_READ abandoned");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_addi();
    test_lw();
    test_sw();
    test_branch();
    test_jalr();
    test_upper();
    test_trap();
    test_reset_mid_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing FSM for the multicycle variant of the rv32i core: a single shared instruction/data memory, IR/ALUOut/Data registers, and one ALU reused for PC+4, branch target and execution. Each cycle it decodes its state and the latched instruction fields into datapath mux selects and write enables. It stalls on a memory ready handshake and traps on unsupported opcodes. The ALU-function decoder stays a separate block driven by `alu_op_o`.

## Interface
- No parameters.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `op_i` in 7: opcode from IR[6:0].
- `funct3_i` in 3: IR[14:12].
- `zero_i` in 1: ALU zero flag.
- `less_than_i` in 1: ALU result bit 0 (slt/sltu outcome).
- `mem_ready_i` in 1: memory completes the current request this cycle.
- `mem_req_o` out 1: memory request valid.
- `mem_write_o` out 1: request is a store.
- `adr_src_o` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write_o` out 1: load IR and OldPC.
- `pc_write_o` out 1: load PC from the result bus.
- `reg_write_o` out 1: register-file write.
- `alu_src_a_o` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `alu_src_b_o` out 2: ALU B select; 00 = rs2, 01 = imm_ext, 10 = 4.
- `alu_op_o` out 2: ALU op class; 00 = add, 01 = branch compare, 10 = funct-decoded.
- `result_src_o` out 2: result bus select; 00 = ALUOut, 01 = Data register, 10 = ALU result direct.
- `trap_o` out 1: illegal opcode seen; core halted.
- `state_o` out 4: current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, JALR=11, UPPER=12, TRAP=15.
- Outputs are Moore on state, except: `ir_write`/`pc_write` in FETCH, and `pc_write` in BRANCH. Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, op=00, result_src=10, ir_write=pc_write=mem_ready_i. Goes to DECODE on mem_ready_i, otherwise holds.
- DECODE: a=01, b=01, op=00, so ALUOut = branch/JAL target. Next state by op_i:
  - 0000011 or 0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UPPER
  - any other opcode → TRAP
- MEM_ADR: a=10, b=01, op=00. Goes to MEM_READ if op_i[5]=0, MEM_WRITE if op_i[5]=1.
- MEM_READ: mem_req=1, adr_src=1, result_src=00. Goes to MEM_WB on ready, otherwise holds.
- MEM_WB: result_src=01, reg_write=1. Goes to FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. Goes to FETCH on ready, otherwise holds.
- EXEC_R: a=10, b=00, op=10. Goes to ALU_WB.
- EXEC_I: a=10, b=01, op=10. Goes to ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Goes to FETCH.
- BRANCH: a=10, b=00, op=01, result_src=00. Goes to FETCH. pc_write = taken, where:
  - funct3 000: taken = zero_i
  - funct3 001: taken = !zero_i
  - funct3 100 or 110: taken = less_than_i
  - funct3 101 or 111: taken = !less_than_i
  - funct3 010 or 011: taken = 0
- JAL: a=01, b=10, op=00, result_src=00, pc_write=1. PC ← ALUOut (target); ALU computes OldPC+4. Goes to ALU_WB.
- JALR: a=10, b=01, op=00. Writes ALUOut = rs1+imm. Goes to JAL. Clearing bit 0 of the target is the datapath's job.
- UPPER: a=11 if op_i[5]=1 (lui), a=01 if op_i[5]=0 (auipc); b=01, op=00. Goes to ALU_WB.
- TRAP: trap_o=1, all enables 0. Stays in TRAP until reset.
- op_i and funct3_i are sampled only in DECODE, MEM_ADR, BRANCH and UPPER; they come from IR, which is stable after FETCH.

## Timing
- Reset: on a clock edge with rst_i=1, state ← FETCH.
- While rst_i=1, all enable outputs are forced to 0: mem_req, mem_write, ir_write, pc_write, reg_write, trap. mem_ready_i is ignored.
- Selects read 0, 00, 00, 00 and 00 during reset; state_o reads the registered state.
- Reset mid-request (e.g. in MEM_READ) abandons the request. No write enable is asserted on that edge.
- Cycles per instruction with zero wait states:
  - load 5, store 4
  - R-type, I-type, lui, auipc 4
  - branch 3
  - jal 4, jalr 5
- Each cycle with mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. mem_req_o and all selects stay stable while stalled.
- mem_ready_i outside memory states is ignored.

## Test plan
- Reset: hold rst_i 2 cycles → state_o=0, all enables 0. Release with mem_ready_i=1 → FETCH asserts ir_write and pc_write in the same cycle.
- addi (op 0010011), ready always 1 → states 0,1,7,8,0. reg_write=1 only in state 8, with result_src=00.
- lw with mem_ready_i low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0. mem_req=1 and adr_src=1 held throughout. reg_write in state 4 with result_src=01.
- bne (funct3 001): zero_i=1 → pc_write=0; zero_i=0 → pc_write=1. Both in state 9, 3 cycles total.
- jalr → states 0,1,11,10,8,0. pc_write=1 only in state 10 (plus FETCH). reg_write in state 8.
- op 0001111 → TRAP (15), trap_o=1, remains there for 10 cycles. rst_i=1 → FETCH.
